traffic_light_monitor: RTL and testbench

- Independent safety monitor on the lamp side of the two-street traffic light controller.
- Samples the six lamp outputs (Ra, Ya, Ga, Rb, Yb, Gb) every cycle and decodes them into a phase.
- Checks phase ordering and dwell times against the timing plan.
- On any violation, latches a fault code and drives a flashing-red override request to the lamp drivers.

---
 rtl/traffic_light_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Independent safety monitor for a two-street traffic light
//               controller. Registers the six lamp outputs, decodes them
//               into a phase (P0..P3), and checks phase ordering and dwell
//               times against the timing plan. On a violation it latches a
//               fault code and requests a flashing-red lamp override.
//
// Ports       : clk          - clock (single domain)
//               reset        - synchronous reset, active high
//               Ra,Ya,Ga     - street A lamps from the controller
//               Rb,Yb,Gb     - street B lamps from the controller
//               clr          - synchronous fault-clear pulse (FAULT only)
//               phase        - current decoded phase
//               phase_valid  - monitor is tracking (RUN state)
//               dwell        - cycles spent in the current phase
//               fault        - latched fault flag
//               fault_code   - 0 none, 1 illegal pattern, 2 illegal
//                              transition, 3 min-dwell, 4 yellow overrun
//               ovr          - lamp override request
//               ovr_Ra/Rb    - flashing red, meaningful when ovr=1
//
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int CNT_W      = 28,
    parameter int MIN_GA     = 60_000_000,
    parameter int MIN_YEL    = 10_000_000,
    parameter int MAX_YEL    = 10_000_100,
    parameter int MIN_GB     = 50_000_000,
    parameter int GLITCH_CYC = 2,
    parameter int FLASH_HALF = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ra,
    input  logic             Ya,
    input  logic             Ga,
    input  logic             Rb,
    input  logic             Yb,
    input  logic             Gb,
    input  logic             clr,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [CNT_W-1:0] dwell,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             ovr,
    output logic             ovr_Ra,
    output logic             ovr_Rb
);

    // Monitor states
    localparam logic [1:0] c_S_SYNC  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_FAULT = 2'd2;

    // Fault codes
    localparam logic [2:0] c_CODE_NONE  = 3'd0;
    localparam logic [2:0] c_CODE_ILL   = 3'd1;
    localparam logic [2:0] c_CODE_TRANS = 3'd2;
    localparam logic [2:0] c_CODE_MIN   = 3'd3;
    localparam logic [2:0] c_CODE_YOVR  = 3'd4;

    // Lamp vector order {Ra,Ya,Ga,Rb,Yb,Gb}
    localparam logic [5:0] c_PAT_P0 = 6'b001_100;   // Ga + Rb
    localparam logic [5:0] c_PAT_P1 = 6'b010_100;   // Ya + Rb
    localparam logic [5:0] c_PAT_P2 = 6'b100_001;   // Ra + Gb
    localparam logic [5:0] c_PAT_P3 = 6'b100_010;   // Ra + Yb

    localparam logic [CNT_W-1:0] c_MIN_GA     = CNT_W'(MIN_GA);
    localparam logic [CNT_W-1:0] c_MIN_YEL    = CNT_W'(MIN_YEL);
    localparam logic [CNT_W-1:0] c_MIN_GB     = CNT_W'(MIN_GB);
    localparam logic [CNT_W-1:0] c_YEL_OVR    = CNT_W'(MAX_YEL + 1);
    localparam logic [CNT_W-1:0] c_FLASH_HALF = CNT_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] c_FLASH_LAST = CNT_W'(2 * FLASH_HALF - 1);

    localparam int               c_ILL_W    = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC + 1) : 1;
    localparam logic [c_ILL_W-1:0] c_ILL_LAST = c_ILL_W'(GLITCH_CYC - 1);

    logic [1:0]         r_state;
    logic [5:0]         r_lamp;
    logic [1:0]         r_phase;
    logic               r_valid;
    logic [CNT_W-1:0]   r_dwell;
    logic               r_first;      // tracking the partial phase seen at sync
    logic [c_ILL_W-1:0] r_ill;        // consecutive illegal samples
    logic               r_fault;
    logic [2:0]         r_code;
    logic               r_ovr;
    logic               r_ovr_red;
    logic [CNT_W-1:0]   r_flash;

    logic               w_legal;
    logic [1:0]         w_dec;
    logic [1:0]         w_next_ph;
    logic [CNT_W-1:0]   w_min;
    logic [CNT_W-1:0]   w_dwell_inc;
    logic               w_ill_hit;
    logic               w_viol;
    logic [2:0]         w_code;
    logic [CNT_W-1:0]   w_flash_nxt;

    always_comb begin
        w_legal = 1'b1;
        w_dec   = 2'd0;
        case (r_lamp)
            c_PAT_P0: w_dec = 2'd0;
            c_PAT_P1: w_dec = 2'd1;
            c_PAT_P2: w_dec = 2'd2;
            c_PAT_P3: w_dec = 2'd3;
            default:  w_legal = 1'b0;
        endcase

        w_next_ph = r_phase + 2'd1;

        // Minimum dwell of the phase being left
        case (r_phase)
            2'd0:    w_min = c_MIN_GA;
            2'd2:    w_min = c_MIN_GB;
            default: w_min = c_MIN_YEL;
        endcase

        w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + CNT_W'(1);
        w_ill_hit   = !w_legal && (r_ill == c_ILL_LAST);

        // Violation detection; the if/else order gives code 1 > 2 > 3 > 4
        w_viol = 1'b0;
        w_code = c_CODE_NONE;
        if ((r_state == c_S_SYNC) || (r_state == c_S_RUN)) begin
            if (!w_legal) begin
                if (w_ill_hit) begin
                    w_viol = 1'b1;
                    w_code = c_CODE_ILL;
                end
            end else if (r_state == c_S_RUN) begin
                if (w_dec == r_phase) begin
                    // Yellow phases are the odd ones (P1, P3)
                    if (r_phase[0] && (w_dwell_inc == c_YEL_OVR)) begin
                        w_viol = 1'b1;
                        w_code = c_CODE_YOVR;
                    end
                end else if (w_dec == w_next_ph) begin
                    if (!r_first && (r_dwell < w_min)) begin
                        w_viol = 1'b1;
                        w_code = c_CODE_MIN;
                    end
                end else begin
                    w_viol = 1'b1;
                    w_code = c_CODE_TRANS;
                end
            end
        end

        w_flash_nxt = (r_flash == c_FLASH_LAST) ? '0 : r_flash + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_S_SYNC;
            r_lamp    <= '0;
            r_phase   <= '0;
            r_valid   <= 1'b0;
            r_dwell   <= '0;
            r_first   <= 1'b0;
            r_ill     <= '0;
            r_fault   <= 1'b0;
            r_code    <= c_CODE_NONE;
            r_ovr     <= 1'b0;
            r_ovr_red <= 1'b0;
            r_flash   <= '0;
        end else begin
            r_lamp <= {Ra, Ya, Ga, Rb, Yb, Gb};

            case (r_state)
                c_S_SYNC, c_S_RUN: begin
                    if (w_viol) begin
                        // Phase and dwell stay frozen at their pre-fault values
                        r_state   <= c_S_FAULT;
                        r_fault   <= 1'b1;
                        r_code    <= w_code;
                        r_valid   <= 1'b0;
                        r_ovr     <= 1'b1;
                        r_ovr_red <= 1'b1;
                        r_flash   <= '0;
                        r_ill     <= '0;
                    end else if (!w_legal) begin
                        // Glitch being filtered: phase and dwell hold
                        r_ill <= r_ill + c_ILL_W'(1);
                    end else begin
                        r_ill <= '0;
                        if (r_state == c_S_SYNC) begin
                            r_phase <= w_dec;
                            r_dwell <= CNT_W'(1);
                            r_valid <= 1'b1;
                            r_first <= 1'b1;
                            r_state <= c_S_RUN;
                        end else if (w_dec == r_phase) begin
                            r_dwell <= w_dwell_inc;
                        end else begin
                            // Only a legal advance reaches here without a violation
                            r_phase <= w_dec;
                            r_dwell <= CNT_W'(1);
                            r_first <= 1'b0;
                        end
                    end
                end

                c_S_FAULT: begin
                    if (clr) begin
                        r_state   <= c_S_SYNC;
                        r_fault   <= 1'b0;
                        r_code    <= c_CODE_NONE;
                        r_ovr     <= 1'b0;
                        r_ovr_red <= 1'b0;
                        r_flash   <= '0;
                        r_ill     <= '0;
                    end else begin
                        // Red on for the first half of each flash period
                        r_flash   <= w_flash_nxt;
                        r_ovr_red <= (w_flash_nxt < c_FLASH_HALF);
                    end
                end

                default: r_state <= c_S_SYNC;
            endcase
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_valid;
    assign dwell       = r_dwell;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign ovr         = r_ovr;
    assign ovr_Ra      = r_ovr_red;
    assign ovr_Rb      = r_ovr_red;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Self-checking bench for traffic_light_monitor using scaled
//               timing (MIN_GA=6, MIN_YEL=2, MAX_YEL=3, MIN_GB=5,
//               GLITCH_CYC=2, FLASH_HALF=4). Table of per-cycle vectors with
//               hand-computed outputs, followed by short directed sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam int c_CNT_W = 8;

    // Lamp vector order {Ra,Ya,Ga,Rb,Yb,Gb}
    localparam logic [5:0] c_L0   = 6'b001_100;
    localparam logic [5:0] c_L1   = 6'b010_100;
    localparam logic [5:0] c_L2   = 6'b100_001;
    localparam logic [5:0] c_L3   = 6'b100_010;
    localparam logic [5:0] c_LOFF = 6'b000_000;
    localparam logic [5:0] c_LGG  = 6'b001_001;   // Ga + Gb

    logic clk = 1'b0;
    logic reset, clr;
    logic Ra, Ya, Ga, Rb, Yb, Gb;
    logic [1:0]         phase;
    logic               phase_valid;
    logic [c_CNT_W-1:0] dwell;
    logic               fault;
    logic [2:0]         fault_code;
    logic               ovr, ovr_Ra, ovr_Rb;

    int n_vec  = 0;
    int n_miss = 0;

    // ph / dw of -1 mean "not checked"
    typedef struct {
        logic       rst;
        logic       clr;
        logic [5:0] lamps;
        int         ph;
        logic       vld;
        int         dw;
        logic       flt;
        logic [2:0] code;
        logic       ov;
        logic       red;
    } vec_t;

    vec_t vq[$];

    traffic_light_monitor #(
        .CNT_W      (c_CNT_W),
        .MIN_GA     (6),
        .MIN_YEL    (2),
        .MAX_YEL    (3),
        .MIN_GB     (5),
        .GLITCH_CYC (2),
        .FLASH_HALF (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Ra          (Ra),
        .Ya          (Ya),
        .Ga          (Ga),
        .Rb          (Rb),
        .Yb          (Yb),
        .Gb          (Gb),
        .clr         (clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .dwell       (dwell),
        .fault       (fault),
        .fault_code  (fault_code),
        .ovr         (ovr),
        .ovr_Ra      (ovr_Ra),
        .ovr_Rb      (ovr_Rb)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic c, input logic [5:0] l,
                       input int ph, input logic v, input int dw,
                       input logic f, input logic [2:0] cd,
                       input logic o, input logic od);
        vec_t t;
        t.rst = r;  t.clr = c;  t.lamps = l;
        t.ph  = ph; t.vld = v;  t.dw    = dw;
        t.flt = f;  t.code = cd; t.ov   = o; t.red = od;
        vq.push_back(t);
    endtask

    // Drive inputs mid-cycle, then sample 1 time unit after the rising edge
    task automatic step(input logic r, input logic c, input logic [5:0] l);
        @(negedge clk);
        reset = r;
        clr   = c;
        {Ra, Ya, Ga, Rb, Yb, Gb} = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int ph, input logic v,
                         input int dw, input logic f, input logic [2:0] cd,
                         input logic o, input logic od);
        logic bad;
        bad = (phase_valid !== v) || (fault !== f) || (fault_code !== cd) ||
              (ovr !== o) || (ovr_Ra !== od) || (ovr_Rb !== od);
        if ((ph >= 0) && (phase !== 2'(ph)))       bad = 1'b1;
        if ((dw >= 0) && (dwell !== c_CNT_W'(dw))) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_miss++;
            $display("FAIL %s: got ph=%0d vld=%0b dw=%0d flt=%0b code=%0d ovr=%0b ra=%0b rb=%0b; want ph=%0d vld=%0b dw=%0d flt=%0b code=%0d ovr=%0b red=%0b",
                     name, phase, phase_valid, dwell, fault, fault_code, ovr, ovr_Ra, ovr_Rb,
                     ph, v, dw, f, cd, o, od);
        end
    endtask

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        {Ra, Ya, Ga, Rb, Yb, Gb} = c_LOFF;

        // ---- Legal cycle: P0x8, P1x2, P2x5, P3x3, P0 ----
        add(1,0,c_L0, 0,0,0, 0,0,0,0);             // reset values
        add(0,0,c_L0, 0,0,0, 0,0,0,0);             // reset lamp_q=0 seen once
        add(0,0,c_L0, 0,1,1, 0,0,0,0);             // sync onto P0
        for (int i = 2; i <= 7; i++) add(0,0,c_L0, 0,1,i, 0,0,0,0);
        add(0,0,c_L1, 0,1,8, 0,0,0,0);
        add(0,0,c_L1, 1,1,1, 0,0,0,0);
        add(0,0,c_L2, 1,1,2, 0,0,0,0);
        add(0,0,c_L2, 2,1,1, 0,0,0,0);
        add(0,0,c_L2, 2,1,2, 0,0,0,0);
        add(0,0,c_L2, 2,1,3, 0,0,0,0);
        add(0,0,c_L2, 2,1,4, 0,0,0,0);
        add(0,0,c_L3, 2,1,5, 0,0,0,0);
        add(0,0,c_L3, 3,1,1, 0,0,0,0);
        add(0,0,c_L3, 3,1,2, 0,0,0,0);
        add(0,0,c_L0, 3,1,3, 0,0,0,0);             // yellow at MAX_YEL, no overrun
        add(0,0,c_L0, 0,1,1, 0,0,0,0);
        // ---- Glitch filter ----
        add(0,0,c_LOFF, 0,1,2, 0,0,0,0);
        add(0,0,c_L0,   0,1,2, 0,0,0,0);           // single glitch: dwell holds
        add(0,0,c_L0,   0,1,3, 0,0,0,0);
        add(0,0,c_LGG,  0,1,4, 0,0,0,0);
        add(0,0,c_LGG,  0,1,4, 0,0,0,0);
        add(0,0,c_L0,   0,0,4, 1,1,1,1);           // second Ga+Gb sample: code 1
        // ---- Flash pattern 1,1,1,1,0,0,0,0,1; further faults ignored ----
        add(0,0,c_L0,   0,0,4, 1,1,1,1);
        add(0,0,c_L0,   0,0,4, 1,1,1,1);
        add(0,0,c_L0,   0,0,4, 1,1,1,1);
        add(0,0,c_L2,   0,0,4, 1,1,1,0);
        add(0,0,c_LGG,  0,0,4, 1,1,1,0);
        add(0,0,c_LGG,  0,0,4, 1,1,1,0);
        add(0,0,c_L0,   0,0,4, 1,1,1,0);
        add(0,0,c_L0,   0,0,4, 1,1,1,1);
        // ---- clr, resync onto P2 (partial phase exempt from min dwell) ----
        add(0,1,c_L2,  -1,0,-1, 0,0,0,0);
        add(0,0,c_L2,   2,1,1, 0,0,0,0);
        add(0,0,c_L3,   2,1,2, 0,0,0,0);
        add(0,0,c_L3,   3,1,1, 0,0,0,0);
        // ---- Short green ----
        add(0,0,c_L3,   3,1,2, 0,0,0,0);
        add(0,0,c_L0,   3,1,3, 0,0,0,0);
        add(0,0,c_L0,   0,1,1, 0,0,0,0);
        add(0,0,c_L0,   0,1,2, 0,0,0,0);
        add(0,0,c_L1,   0,1,3, 0,0,0,0);
        add(0,0,c_L1,   0,0,3, 1,3,1,1);           // P0 for 3 < 6: code 3
        add(0,0,c_L1,   0,0,3, 1,3,1,1);
        // ---- Skip P0 -> P2 ----
        add(0,1,c_L0,  -1,0,-1, 0,0,0,0);
        add(0,0,c_L0,   0,1,1, 0,0,0,0);
        for (int i = 2; i <= 5; i++) add(0,0,c_L0, 0,1,i, 0,0,0,0);
        add(0,0,c_L2,   0,1,6, 0,0,0,0);
        add(0,0,c_L2,   0,0,6, 1,2,1,1);           // code 2
        // ---- Yellow overrun on a non-initial P1 ----
        add(0,1,c_L3,  -1,0,-1, 0,0,0,0);
        add(0,0,c_L0,   3,1,1, 0,0,0,0);
        add(0,0,c_L0,   0,1,1, 0,0,0,0);
        for (int i = 2; i <= 5; i++) add(0,0,c_L0, 0,1,i, 0,0,0,0);
        add(0,0,c_L1,   0,1,6, 0,0,0,0);
        add(0,0,c_L1,   1,1,1, 0,0,0,0);
        add(0,0,c_L1,   1,1,2, 0,0,0,0);
        add(0,0,c_L1,   1,1,3, 0,0,0,0);
        add(0,0,c_L0,   1,0,-1, 1,4,1,1);          // 4th P1 sample: code 4
        add(0,0,c_L0,   1,0,-1, 1,4,1,1);
        // ---- Reset precedence over clr in FAULT, and reset mid-P2 ----
        add(1,1,c_L0,   0,0,0, 0,0,0,0);
        add(0,0,c_L2,   0,0,0, 0,0,0,0);
        add(0,0,c_L2,   2,1,1, 0,0,0,0);
        add(0,0,c_L2,   2,1,2, 0,0,0,0);
        add(1,0,c_L2,   0,0,0, 0,0,0,0);
        add(0,0,c_L0,   0,0,0, 0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].clr, vq[i].lamps);
            check($sformatf("vec%0d", i), vq[i].ph, vq[i].vld, vq[i].dw,
                  vq[i].flt, vq[i].code, vq[i].ov, vq[i].red);
        end

        // ---- clr outside FAULT has no effect: sync and count with clr high ----
        step(0, 1, c_L0);
        check("clr_run_sync", 0, 1, 1, 0, 0, 0, 0);
        for (int i = 2; i <= 5; i++) begin
            step(0, 1, c_L0);
            check($sformatf("clr_run_dw%0d", i), 0, 1, i, 0, 0, 0, 0);
        end
        step(0, 0, c_L0);
        check("clr_run_end", 0, 1, 6, 0, 0, 0, 0);

        // ---- Illegal pattern fault while still in SYNC ----
        step(1, 0, c_LOFF);
        check("sync_ill_rst", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, c_LOFF);
        check("sync_ill_1", 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, c_LOFF);
        check("sync_ill_2", 0, 0, 0, 1, 1, 1, 1);
        step(1, 0, c_LOFF);
        check("sync_ill_rst2", 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
